// File: rtl/midi_sysex_extractor.sv
// Extracts SysEx frames (F0..F7) from a raw MIDI byte stream into an FWFT FIFO.
// Define MIDI_SYSEX_STATS_EN to add the msg_cnt/drop_cnt/stall_cnt statistics outputs.
module midi_sysex_extractor #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  sysex_data,
    output logic        sysex_valid,
    output logic        sysex_last,
    input  logic        sysex_rd,
    input  logic        sysex_busy,
`ifdef MIDI_SYSEX_STATS_EN
    output logic [15:0] msg_cnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] stall_cnt,
`endif
    output logic        in_sysex,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] cnt_t;
    typedef enum logic [1:0] {StIdle, StBody, StDrop} state_e;

    // Room for the start byte plus a guaranteed terminator slot.
    localparam cnt_t LimStart = cnt_t'(DEPTH - 2);
    // A restart F0 lands one entry after the synthetic terminator.
    localparam cnt_t LimRestart = cnt_t'(DEPTH - 3);
    localparam cnt_t CntFull = cnt_t'(DEPTH);

    state_e        state_q, state_d;
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_d;
    cnt_t          cnt_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [8:0]    mem [DEPTH];

    logic       push, pop;
    logic [8:0] wdata;
    logic       inc_msg, inc_drop;
    logic       byte_ok, is_f0, is_f7, is_d;

    // Real-time bytes are invisible; rx during a pending-F0 write cannot occur (UART gap).
    assign byte_ok = rx_valid && !pend_q && (rx_data < 8'hF8);
    assign is_f0   = (rx_data == 8'hF0);
    assign is_f7   = (rx_data == 8'hF7);
    assign is_d    = !rx_data[7];

    always_comb begin
        state_d  = state_q;
        pend_d   = 1'b0;
        ovf_d    = 1'b0;
        push     = 1'b0;
        wdata    = '0;
        inc_msg  = 1'b0;
        inc_drop = 1'b0;
        if (pend_q) begin
            push  = 1'b1;
            wdata = {1'b0, 8'hF0};
        end else if (byte_ok) begin
            unique case (state_q)
                StIdle, StDrop: begin
                    if (is_f0) begin
                        if (cnt_q <= LimStart) begin
                            push    = 1'b1;
                            wdata   = {1'b0, 8'hF0};
                            state_d = StBody;
                        end else begin
                            inc_drop = 1'b1;
                            state_d  = StDrop;
                        end
                    end else if (state_q == StDrop && !is_d) begin
                        state_d = StIdle;
                    end
                end
                StBody: begin
                    push = 1'b1;
                    if (is_d) begin
                        if (cnt_q <= LimStart) begin
                            wdata = {1'b0, rx_data};
                        end else begin
                            wdata    = {1'b1, 8'hF7};
                            ovf_d    = 1'b1;
                            inc_drop = 1'b1;
                            state_d  = StDrop;
                        end
                    end else if (is_f7) begin
                        wdata   = {1'b1, 8'hF7};
                        inc_msg = 1'b1;
                        state_d = StIdle;
                    end else if (is_f0) begin
                        wdata = {1'b1, 8'hF7};
                        if (cnt_q <= LimRestart) begin
                            pend_d = 1'b1;
                        end else begin
                            inc_drop = 1'b1;
                            state_d  = StDrop;
                        end
                    end else begin
                        wdata   = {1'b1, 8'hF7};
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pop = sysex_rd && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= wdata;
    end

    assign sysex_valid = (cnt_q != '0);
    assign sysex_data  = sysex_valid ? mem[rptr_q][7:0] : 8'h00;
    assign sysex_last  = sysex_valid ? mem[rptr_q][8] : 1'b0;
    assign in_sysex    = (state_q == StBody);
    assign overflow    = ovf_q;

    no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && cnt_q == CntFull));

`ifdef MIDI_SYSEX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_cnt   <= '0;
            drop_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (inc_msg)                   msg_cnt   <= msg_cnt + 1'b1;
            if (inc_drop)                  drop_cnt  <= drop_cnt + 1'b1;
            if (sysex_valid && sysex_busy) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = inc_msg ^ inc_drop ^ sysex_busy;
`endif

endmodule

// File: tb/tb_midi_sysex_extractor.sv
// Self-checking bench for midi_sysex_extractor: frame-level queue model plus literal stream checks.
module tb_midi_sysex_extractor;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  sysex_data;
    logic        sysex_valid, sysex_last;
    logic        sysex_rd = 1'b0;
    logic        sysex_busy = 1'b0;
    logic        in_sysex, overflow;
`ifdef MIDI_SYSEX_STATS_EN
    logic [15:0] msg_cnt, drop_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    midi_sysex_extractor #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .sysex_data (sysex_data),
        .sysex_valid(sysex_valid),
        .sysex_last (sysex_last),
        .sysex_rd   (sysex_rd),
        .sysex_busy (sysex_busy),
`ifdef MIDI_SYSEX_STATS_EN
        .msg_cnt    (msg_cnt),
        .drop_cnt   (drop_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .in_sysex   (in_sysex),
        .overflow   (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: the FIFO is a queue of {last,data}; mode 0=idle, 1=in frame, 2=dropping.
    logic [8:0]  m_q[$];
    int          m_mode = 0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_msg = 0, m_drop = 0, m_stall = 0;
    int          m_sz;

    task automatic model_start();
        if (m_sz <= DEPTH - 2) begin
            m_q.push_back({1'b0, 8'hF0});
            m_mode = 1;
        end else begin
            m_drop++;
            m_mode = 2;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'hF8) return;
        if (m_mode != 1) begin
            if (b == 8'hF0) model_start();
            else if (m_mode == 2 && b >= 8'h80) m_mode = 0;
        end else if (b < 8'h80) begin
            if (m_sz <= DEPTH - 2) m_q.push_back({1'b0, b});
            else begin
                m_q.push_back({1'b1, 8'hF7});
                m_ovf = 1'b1;
                m_drop++;
                m_mode = 2;
            end
        end else begin
            m_q.push_back({1'b1, 8'hF7});
            if (b == 8'hF7) begin
                m_msg++;
                m_mode = 0;
            end else if (b == 8'hF0) begin
                // Restart needs space for its F0 next to the terminator just queued.
                if (m_sz + 1 <= DEPTH - 2) begin
                    m_q.push_back({1'b0, 8'hF0});
                    m_mode = 1;
                end else begin
                    m_drop++;
                    m_mode = 2;
                end
            end else begin
                m_mode = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_mode = 0;
            m_ovf = 1'b0;
            m_msg = 0;
            m_drop = 0;
            m_stall = 0;
        end else begin
            m_sz = m_q.size();
            m_ovf = 1'b0;
            if (sysex_busy && m_sz != 0) m_stall++;
            if (rx_valid) model_byte(rx_data);
            if (sysex_rd && m_sz != 0) void'(m_q.pop_front());
        end
    end

    logic [8:0] got_q[$];
    logic [8:0] lit_q[$];
    int         ovf_seen = 0;
    int         valid_seen = 0;

    always @(negedge clk) begin
        chk("valid", sysex_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("data", sysex_data, m_q[0][7:0]);
            chk("last", sysex_last, m_q[0][8]);
        end
        chk("in_sysex", in_sysex, m_mode == 1);
        chk("overflow", overflow, m_ovf);
`ifdef MIDI_SYSEX_STATS_EN
        chk("msg_cnt", msg_cnt, m_msg);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        if (overflow) ovf_seen++;
        if (sysex_valid) valid_seen++;
        if (sysex_valid && sysex_rd) got_q.push_back({sysex_last, sysex_data});
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        got_q.delete();
        ovf_seen = 0;
        valid_seen = 0;
    endtask

    task automatic drain();
        sysex_rd = 1'b1;
        for (int i = 0; i < 100 && sysex_valid; i++) @(posedge clk);
        #1;
        chk("drain_done", sysex_valid, 1'b0);
    endtask

    task automatic check_seq(input string nm);
        chk({nm, "_len"}, got_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
            chk(nm, got_q[i], lit_q[i]);
        got_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", sysex_valid, 1'b0);
        chk("reset_data", sysex_data, 8'h00);
        chk("reset_in_sysex", in_sysex, 1'b0);
        rst = 1'b1;

        // T1 basic frame with continuous reads
        sysex_rd = 1'b1;
        send(8'hF0); send(8'h7E); send(8'h7F); send(8'h09); send(8'h01); send(8'hF7);
        drain();
        lit_q = '{9'h0F0, 9'h07E, 9'h07F, 9'h009, 9'h001, 9'h1F7};
        check_seq("t1_stream");
`ifdef MIDI_SYSEX_STATS_EN
        chk("t1_msg_cnt", msg_cnt, 16'd1);
`endif

        // T2 real-time bytes interleaved
        do_reset();
        send(8'hF0); send(8'h43); send(8'hF8); send(8'h10); send(8'hFE); send(8'hF7);
        drain();
        lit_q = '{9'h0F0, 9'h043, 9'h010, 9'h1F7};
        check_seq("t2_stream");

        // T3 abort by status byte
        do_reset();
        send(8'hF0); send(8'h43); send(8'h12); send(8'h90); send(8'h3C); send(8'h40);
        drain();
        lit_q = '{9'h0F0, 9'h043, 9'h012, 9'h1F7};
        check_seq("t3_stream");
        chk("t3_idle", in_sysex, 1'b0);

        // T4 overflow with no reads and downstream busy
        do_reset();
        sysex_rd = 1'b0;
        sysex_busy = 1'b1;
        send(8'hF0);
        for (int i = 1; i <= 20; i++) send(8'(i));
        send(8'hF7);
        #1;
        chk("t4_full_valid", sysex_valid, 1'b1);
        chk("t4_ovf_pulses", ovf_seen, 1);
        sysex_busy = 1'b0;
        drain();
        lit_q = {};
        lit_q.push_back(9'h0F0);
        for (int i = 1; i <= 14; i++) lit_q.push_back(9'(i));
        lit_q.push_back(9'h1F7);
        check_seq("t4_stream");
        send(8'hF0); send(8'h01); send(8'hF7);
        drain();
        lit_q = '{9'h0F0, 9'h001, 9'h1F7};
        check_seq("t4_after");
`ifdef MIDI_SYSEX_STATS_EN
        chk("t4_drop_cnt", drop_cnt, 16'd1);
        chk("t4_msg_cnt", msg_cnt, 16'd1);
`endif

        // T5 stray bytes while idle
        do_reset();
        send(8'h01); send(8'h02); send(8'hF7); send(8'h80); send(8'h00);
        chk("t5_valid_cycles", valid_seen, 0);

        // T7 F0 inside a frame closes it and restarts
        send(8'hF0); send(8'h01); send(8'hF0); send(8'h02); send(8'hF7);
        drain();
        lit_q = '{9'h0F0, 9'h001, 9'h1F7, 9'h0F0, 9'h002, 9'h1F7};
        check_seq("t7_stream");

        // T6 asynchronous reset mid-frame
        do_reset();
        sysex_rd = 1'b0;
        send(8'hF0); send(8'h01); send(8'h02);
        #1;
        chk("t6_pre_valid", sysex_valid, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_async_valid", sysex_valid, 1'b0);
        chk("t6_async_in_sysex", in_sysex, 1'b0);
`ifdef MIDI_SYSEX_STATS_EN
        chk("t6_msg_zero", msg_cnt, 16'd0);
        chk("t6_drop_zero", drop_cnt, 16'd0);
        chk("t6_stall_zero", stall_cnt, 16'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        got_q.delete();
        sysex_rd = 1'b1;
        send(8'hF0); send(8'h05); send(8'hF7);
        drain();
        lit_q = '{9'h0F0, 9'h005, 9'h1F7};
        check_seq("t6_stream");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
